// File: rtl/ifu_pc_unit.sv
// Instruction-fetch PC unit for the single-cycle MIPS core.
// Holds the architectural PC, selects the next PC (seq/branch/jump/jr),
// checks it against the instruction memory window and halts on a fetch fault.
module ifu_pc_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_take,
  input  logic [15:0] im16,
  input  logic [25:0] im26,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  // Last word address that may legally be fetched.
  localparam logic [31:0] PcLast = PC_RESET + (IM_WORDS * 32'd4) - 32'd4;

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  localparam logic [1:0] SelSeq  = 2'b00;
  localparam logic [1:0] SelBr   = 2'b01;
  localparam logic [1:0] SelJump = 2'b10;
  localparam logic [1:0] SelJr   = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        next_legal;

  // Next-PC selection and legality against the fetch window.
  always_comb begin
    pc_plus4_w = pc_q + 32'd4;
    br_off     = {{14{im16[15]}}, im16, 2'b00};
    next_pc    = pc_plus4_w;
    case (npc_sel)
      SelSeq:  next_pc = pc_plus4_w;
      SelBr:   next_pc = br_take ? (pc_plus4_w + br_off) : pc_plus4_w;
      SelJump: next_pc = {pc_plus4_w[31:28], im26, 2'b00};
      SelJr:   next_pc = jr_target;
      default: next_pc = pc_plus4_w;
    endcase
    next_legal = (next_pc[1:0] == 2'b00) && (next_pc >= PC_RESET) && (next_pc <= PcLast);
  end

  // Boot/run/halt sequencing; legality only matters on a non-stalled RUN edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!stall) begin
          if (next_legal) begin
            pc_d    = next_pc;
            count_d = count_q + 32'd1;
          end else begin
            // Keep the faulting instruction's address in pc for debug.
            state_d    = StHalt;
            fault_d    = 1'b1;
            fault_pc_d = next_pc;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StBoot;
    endcase
    valid_d = (state_d == StRun);
  end

  // Architectural state; reset wins over everything, including HALT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StBoot;
      pc_q       <= PC_RESET;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_ifu_pc_unit.sv
// Directed self-checking bench for ifu_pc_unit.
module tb_ifu_pc_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        br_take;
  logic [15:0] im16;
  logic [25:0] im26;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  int n_tests;
  int n_fail;

  ifu_pc_unit #(
    .PC_RESET(32'h0000_3000),
    .IM_WORDS(1024)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .br_take    (br_take),
    .im16       (im16),
    .im26       (im26),
    .jr_target  (jr_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_valid(instr_valid),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [1:0] sel, input logic bt,
                       input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] jr);
    stall = s; npc_sel = sel; br_take = bt; im16 = i16; im26 = i26; jr_target = jr;
  endtask

  // Reset, then boot into RUN cleanly.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    reset_n = 1'b0;
    #12;
    n_tests++;
    if ({pc, instr_valid, fault, fault_pc, fetch_count} !==
        {32'h3000, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h v=%b f=%b fpc=%h cnt=%0d want pc=3000 v=0 f=0 fpc=0 cnt=0",
               pc, instr_valid, fault, fault_pc, fetch_count);
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if ({pc, instr_valid} !== {32'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL boot_cycle: pc=%h v=%b want pc=3000 v=0", pc, instr_valid);
    end
  endtask

  task automatic test_sequential();
    step();
    n_tests++;
    if ({pc, instr_valid, fetch_count} !== {32'h3000, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL boot_to_run: pc=%h v=%b cnt=%0d want pc=3000 v=1 cnt=0",
               pc, instr_valid, fetch_count);
    end
    step();
    n_tests++;
    if ({pc, fetch_count} !== {32'h3004, 32'd1}) begin
      n_fail++;
      $display("FAIL seq1: pc=%h cnt=%0d want pc=3004 cnt=1", pc, fetch_count);
    end
    step();
    n_tests++;
    if ({pc, fetch_count, pc_plus4} !== {32'h3008, 32'd2, 32'h300C}) begin
      n_fail++;
      $display("FAIL seq2: pc=%h cnt=%0d pc4=%h want pc=3008 cnt=2 pc4=300c",
               pc, fetch_count, pc_plus4);
    end
  endtask

  task automatic test_branch();
    // 0x300C + (-2 << 2) = 0x3004
    drive(1'b0, 2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0);
    step();
    n_tests++;
    if ({pc, fetch_count} !== {32'h3004, 32'd3}) begin
      n_fail++;
      $display("FAIL branch_taken: pc=%h cnt=%0d want pc=3004 cnt=3", pc, fetch_count);
    end
    drive(1'b0, 2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    step();
    step();
    n_tests++;
    if ({pc, fetch_count} !== {32'h300C, 32'd5}) begin
      n_fail++;
      $display("FAIL branch_not_taken: pc=%h cnt=%0d want pc=300c cnt=5", pc, fetch_count);
    end
    // Self-branch: 0x3010 + (-1 << 2) = 0x300C
    drive(1'b0, 2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    step();
    n_tests++;
    if ({pc, fetch_count} !== {32'h300C, 32'd6}) begin
      n_fail++;
      $display("FAIL self_branch: pc=%h cnt=%0d want pc=300c cnt=6", pc, fetch_count);
    end
  endtask

  task automatic test_jump();
    drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    step();  // 0x3010, cnt 7
    // br_take must not matter for j
    drive(1'b0, 2'b10, 1'b1, 16'hFFFE, 26'h0000C40, 32'h0);
    step();
    n_tests++;
    if ({pc, fetch_count, pc_plus4} !== {32'h3100, 32'd8, 32'h3104}) begin
      n_fail++;
      $display("FAIL jump: pc=%h cnt=%0d pc4=%h want pc=3100 cnt=8 pc4=3104",
               pc, fetch_count, pc_plus4);
    end
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3020);
    step();
    n_tests++;
    if ({pc, fetch_count} !== {32'h3020, 32'd9}) begin
      n_fail++;
      $display("FAIL jr: pc=%h cnt=%0d want pc=3020 cnt=9", pc, fetch_count);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0);
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if ({pc, fetch_count, fault, instr_valid} !== {32'h3020, 32'd9, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL stall_hold: pc=%h cnt=%0d f=%b v=%b want pc=3020 cnt=9 f=0 v=1",
               pc, fetch_count, fault, instr_valid);
    end
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3040);
    step();
    n_tests++;
    if ({pc, fetch_count} !== {32'h3040, 32'd10}) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h cnt=%0d want pc=3040 cnt=10", pc, fetch_count);
    end
  endtask

  task automatic test_misaligned_fault();
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3022);
    step();
    n_tests++;
    if ({pc, instr_valid, fault, fault_pc, fetch_count} !==
        {32'h3040, 1'b0, 1'b1, 32'h3022, 32'd10}) begin
      n_fail++;
      $display("FAIL misaligned: pc=%h v=%b f=%b fpc=%h cnt=%0d want pc=3040 v=0 f=1 fpc=3022 cnt=10",
               pc, instr_valid, fault, fault_pc, fetch_count);
    end
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3000);
    for (int i = 0; i < 3; i++) step();
    n_tests++;
    if ({pc, instr_valid, fault, fault_pc, fetch_count} !==
        {32'h3040, 1'b0, 1'b1, 32'h3022, 32'd10}) begin
      n_fail++;
      $display("FAIL halt_frozen: pc=%h v=%b f=%b fpc=%h cnt=%0d want pc=3040 v=0 f=1 fpc=3022 cnt=10",
               pc, instr_valid, fault, fault_pc, fetch_count);
    end
    // Asynchronous reset in the middle of a cycle.
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({pc, instr_valid, fault, fault_pc, fetch_count} !==
        {32'h3000, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL async_reset: pc=%h v=%b f=%b fpc=%h cnt=%0d want pc=3000 v=0 f=0 fpc=0 cnt=0",
               pc, instr_valid, fault, fault_pc, fetch_count);
    end
    #2;
    reset_n = 1'b1;
    step();
    n_tests++;
    if ({pc, instr_valid, fetch_count} !== {32'h3000, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL reboot: pc=%h v=%b cnt=%0d want pc=3000 v=1 cnt=0",
               pc, instr_valid, fetch_count);
    end
  endtask

  task automatic test_window_bounds();
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h3FFC);
    step();
    n_tests++;
    if ({pc, fault, fetch_count} !== {32'h3FFC, 1'b0, 32'd1}) begin
      n_fail++;
      $display("FAIL last_word: pc=%h f=%b cnt=%0d want pc=3ffc f=0 cnt=1", pc, fault, fetch_count);
    end
    drive(1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    step();
    n_tests++;
    if ({pc, fault, fault_pc, fetch_count, instr_valid} !==
        {32'h3FFC, 1'b1, 32'h4000, 32'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL fall_off: pc=%h f=%b fpc=%h cnt=%0d v=%b want pc=3ffc f=1 fpc=4000 cnt=1 v=0",
               pc, fault, fault_pc, fetch_count, instr_valid);
    end
    do_reset();
    drive(1'b0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h2FFC);
    step();
    n_tests++;
    if ({pc, fault, fault_pc, fetch_count} !== {32'h3000, 1'b1, 32'h2FFC, 32'd0}) begin
      n_fail++;
      $display("FAIL below_base: pc=%h f=%b fpc=%h cnt=%0d want pc=3000 f=1 fpc=2ffc cnt=0",
               pc, fault, fault_pc, fetch_count);
    end
  endtask

  task automatic test_stall_masks_illegal();
    do_reset();
    drive(1'b1, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0000_0001);
    step();
    step();
    n_tests++;
    if ({pc, fault, instr_valid, fetch_count} !== {32'h3000, 1'b0, 1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL stall_illegal: pc=%h f=%b v=%b cnt=%0d want pc=3000 f=0 v=1 cnt=0",
               pc, fault, instr_valid, fetch_count);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_misaligned_fault();
    test_window_bounds();
    test_stall_masks_illegal();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
